// File: rtl/mux_pkg.sv
// Shared types and constants for the N-channel scan multiplexer.
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n_scan_if.sv
// Sample-side and output-side bus of the scan multiplexer.
// master = upstream/control + downstream side, slave = the multiplexer.
interface mux_n_scan_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ack;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic                      start;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;
    logic                      frame_done;

    modport master (
        output in_data, in_valid, mode, sel, start, out_ready,
        input  in_ack, out_data, out_chan, out_valid, busy, frame_done
    );

    modport slave (
        input  in_data, in_valid, mode, sel, start, out_ready,
        output in_ack, out_data, out_chan, out_valid, busy, frame_done
    );

endinterface

// File: rtl/mux_n_comb.sv
// Combinational CHANNELS:1 word selector; an out-of-range index yields zero.
module mux_n_comb #(
    parameter int  WIDTH    = 16,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          idx,
    output logic [WIDTH-1:0]          data
);

    // OR together the single word whose channel number matches idx
    always_comb begin
        data = {WIDTH{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            data = data | ((idx == SEL_W'(c)) ? in_data[c*WIDTH +: WIDTH] : {WIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/mux_n_scan.sv
// N-channel registered word multiplexer with valid/ready output stage and
// an in-order channel scan sequencer (one sample from each channel per frame).
module mux_n_scan
    import mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic        clk,
    input  logic        reset,
    mux_n_scan_if.slave bus
);

    localparam int              SEL_W   = $clog2(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [SEL_W-1:0]     cnt_r;
    logic [SEL_W-1:0]     cnt_nxt_s;
    logic [SEL_W-1:0]     idx_s;
    logic [WIDTH-1:0]     sel_data_s;
    logic [WIDTH-1:0]     out_data_r;
    logic [SEL_W-1:0]     out_chan_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic                 frame_done_r;
    logic                 frame_done_nxt_s;
    logic                 free_s;
    logic                 idx_ok_s;
    logic                 idx_valid_s;
    logic                 capture_s;
    logic [CHANNELS-1:0]  ack_s;

    // The scan counter owns the selector while scanning; otherwise sel does
    assign idx_s    = (state_r == SCAN) ? cnt_r : bus.sel;
    assign free_s   = !out_valid_r || bus.out_ready;
    assign idx_ok_s = ({1'b0, idx_s} < (SEL_W + 1)'(CHANNELS));

    mux_n_comb #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_sel (
        .in_data (bus.in_data),
        .idx     (idx_s),
        .data    (sel_data_s)
    );

    // Look up the valid bit of the selected channel, guarding out-of-range indices
    always_comb begin
        idx_valid_s = 1'b0;
        if (idx_ok_s) begin
            idx_valid_s = bus.in_valid[idx_s];
        end else begin
            idx_valid_s = 1'b0;
        end
    end

    // Next-state, counter and capture decision
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        capture_s        = 1'b0;
        frame_done_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                case (bus.mode)
                    MODE_DIRECT: begin
                        capture_s = idx_ok_s && idx_valid_s && free_s;
                    end
                    MODE_SCAN: begin
                        if (bus.start) begin
                            state_nxt_s = SCAN;
                            cnt_nxt_s   = {SEL_W{1'b0}};
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
                    default: begin
                        capture_s = 1'b0;
                    end
                endcase
            end
            SCAN: begin
                // An invalid channel stalls here rather than being skipped
                if (idx_valid_s && free_s) begin
                    capture_s = 1'b1;
                    if (cnt_r == LAST_CH) begin
                        state_nxt_s      = IDLE;
                        cnt_nxt_s        = {SEL_W{1'b0}};
                        frame_done_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + SEL_W'(1);
                    end
                end else begin
                    capture_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {SEL_W{1'b0}};
            end
        endcase
    end

    // One-hot consume pulse toward the channel being captured, silenced in reset
    always_comb begin
        ack_s = {CHANNELS{1'b0}};
        if (capture_s && !reset) begin
            ack_s = {{(CHANNELS-1){1'b0}}, 1'b1} << idx_s;
        end else begin
            ack_s = {CHANNELS{1'b0}};
        end
    end

    // FSM state, scan counter and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {SEL_W{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            busy_r       <= (state_nxt_s == SCAN);
            frame_done_r <= frame_done_nxt_s;
        end
    end

    // Output slot: load on capture, empty when free and idle, hold when stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_chan_r  <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (free_s) begin
            if (capture_s) begin
                out_data_r  <= sel_data_s;
                out_chan_r  <= idx_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ack     = ack_s;
    assign bus.out_data   = out_data_r;
    assign bus.out_chan   = out_chan_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_mux_n_scan.sv
// Self-checking bench for mux_n_scan (WIDTH=16, CHANNELS=4).
module tb_mux_n_scan;

    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mux_n_scan_if #(.WIDTH(W), .CHANNELS(N)) bus ();

    mux_n_scan #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // frame plans and per-frame observations
    logic [N-1:0] vplan [64];
    logic         rplan [64];
    logic [W-1:0] word  [N];
    int           r_xchan [$];
    logic [W-1:0] r_xdata [$];
    int           r_ack   [$];
    int           r_hold  [$];
    int           r_fd, r_fd_bad, r_viol, r_timeout, r_idle_busy, r_busy_cnt;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.mode = 1'b0; bus.start = 1'b0; bus.sel = 2'd0;
        bus.in_valid = 4'b0000; bus.out_ready = 1'b1; bus.in_data = 64'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_plans(input bit all_ready);
        for (int c = 0; c < 64; c++) begin
            vplan[c] = 4'b1111;
            rplan[c] = all_ready;
        end
    endtask

    // Drive one scan frame following vplan/rplan and record what the bus shows
    task automatic run_frame(input bit rnd_ctl);
        bit           fd_seen = 1'b0;
        bit           done = 1'b0;
        bit           prev_hold = 1'b0;
        logic [1:0]   p_chan = 2'd0;
        logic [W-1:0] p_data = 16'd0;
        r_xchan.delete(); r_xdata.delete(); r_ack.delete(); r_hold.delete();
        r_fd = 0; r_fd_bad = 0; r_viol = 0; r_idle_busy = 0; r_busy_cnt = 0;
        bus.in_data = {word[3], word[2], word[1], word[0]};
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            bus.in_valid  = vplan[c];
            bus.out_ready = rplan[c];
            if (c == 0) begin
                bus.mode = 1'b1; bus.start = 1'b1; bus.sel = 2'd0;
            end else if (rnd_ctl && !fd_seen) begin
                bus.mode = 1'($urandom); bus.start = 1'($urandom); bus.sel = 2'($urandom);
            end else begin
                bus.mode = 1'b1; bus.start = 1'b0;
            end
            #1;
            if (prev_hold && (!bus.out_valid || bus.out_chan != p_chan || bus.out_data != p_data))
                r_viol++;
            if (bus.out_valid && !bus.out_ready) begin
                r_hold.push_back(int'(bus.out_chan));
                prev_hold = 1'b1; p_chan = bus.out_chan; p_data = bus.out_data;
            end else begin
                prev_hold = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                r_xchan.push_back(int'(bus.out_chan));
                r_xdata.push_back(bus.out_data);
            end
            if (bus.in_ack != 4'b0000) begin
                if (!$onehot(bus.in_ack) || (bus.in_ack & ~bus.in_valid) != 4'b0000 ||
                    (bus.out_valid && !bus.out_ready))
                    r_viol++;
                for (int k = 0; k < N; k++) if (bus.in_ack[k]) r_ack.push_back(k);
            end
            @(posedge clk);
            #1;
            if (bus.busy) r_busy_cnt++;
            if (bus.frame_done) begin
                r_fd++;
                fd_seen = 1'b1;
                if (!(bus.out_valid && bus.out_chan == 2'd3)) r_fd_bad++;
            end
            if (bus.busy && !bus.out_valid) r_idle_busy++;
            if (fd_seen && !bus.out_valid) done = 1'b1;
        end
        r_timeout = done ? 0 : 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; bus.mode = 1'b0; bus.sel = 2'd0; bus.start = 1'b0;
        bus.in_valid = 4'b1111; bus.out_ready = 1'b1; bus.in_data = 64'h1111_2222_3333_4444;
        #1;
        total++;
        if (bus.in_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", bus.in_ack); end
        @(posedge clk); #1;
        total++;
        if ({bus.out_data, bus.out_chan, bus.out_valid, bus.busy, bus.frame_done} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got data=%h chan=%0d v=%b busy=%b fd=%b want all 0",
                     bus.out_data, bus.out_chan, bus.out_valid, bus.busy, bus.frame_done);
        end
        @(negedge clk);
        reset = 1'b0; bus.in_valid = 4'b0000;
    endtask

    task automatic test_direct();
        do_reset();
        @(negedge clk);
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        bus.in_data = 64'hDDDD_CCCC_BBBB_AAAA;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (bus.in_ack !== 4'b0100) begin bad++; $display("FAIL direct_ack cyc=%0d got=%b want=0100", i, bus.in_ack); end
            @(posedge clk); #1;
            total++;
            if (bus.out_data !== 16'hCCCC || bus.out_chan !== 2'd2 || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL direct_out cyc=%0d got data=%h chan=%0d v=%b want CCCC/2/1",
                         i, bus.out_data, bus.out_chan, bus.out_valid);
            end
        end
    endtask

    // Random direct-mode traffic against a model of the output slot rules
    task automatic test_direct_random();
        logic         m_valid = 1'b0;
        logic [W-1:0] m_data = 16'd0;
        logic [1:0]   m_chan = 2'd0;
        logic [3:0]   exp_ack;
        logic [W-1:0] w;
        bit           m_free;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.mode = 1'b0; bus.start = 1'($urandom);
            bus.sel = 2'($urandom); bus.in_valid = 4'($urandom);
            bus.out_ready = ($urandom_range(3, 0) != 0);
            bus.in_data = {$urandom, $urandom};
            #1;
            m_free  = !m_valid || bus.out_ready;
            exp_ack = (bus.in_valid[bus.sel] && m_free) ? (4'b0001 << bus.sel) : 4'b0000;
            w       = bus.in_data[bus.sel*W +: W];
            total++;
            if (bus.in_ack !== exp_ack) begin bad++; $display("FAIL rdirect_ack cyc=%0d got=%b want=%b", i, bus.in_ack, exp_ack); end
            if (m_free) begin
                if (exp_ack != 4'b0000) begin m_valid = 1'b1; m_data = w; m_chan = bus.sel; end
                else m_valid = 1'b0;
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== m_valid || (m_valid && (bus.out_data !== m_data || bus.out_chan !== m_chan))) begin
                bad++;
                $display("FAIL rdirect_out cyc=%0d got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         i, bus.out_valid, bus.out_data, bus.out_chan, m_valid, m_data, m_chan);
            end
            total++;
            if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
                bad++; $display("FAIL rdirect_status got busy=%b fd=%b want 0/0", bus.busy, bus.frame_done);
            end
        end
    endtask

    // Common frame expectations: strict order 0..N-1, words as loaded, one frame_done
    task automatic check_frame(input string name);
        total++;
        if (r_timeout != 0) begin bad++; $display("FAIL %s_timeout got=%0d want=0", name, r_timeout); end
        total++;
        if (r_xchan.size() != N || r_ack.size() != N) begin
            bad++; $display("FAIL %s_count got xfer=%0d ack=%0d want %0d", name, r_xchan.size(), r_ack.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                total++;
                if (r_xchan[k] != k || r_ack[k] != k || r_xdata[k] !== word[k]) begin
                    bad++;
                    $display("FAIL %s_order idx=%0d got chan=%0d ack=%0d data=%h want %0d/%0d/%h",
                             name, k, r_xchan[k], r_ack[k], r_xdata[k], k, k, word[k]);
                end
            end
        end
        total++;
        if (r_fd != 1 || r_fd_bad != 0) begin bad++; $display("FAIL %s_frame_done got n=%0d bad=%0d want 1/0", name, r_fd, r_fd_bad); end
        total++;
        if (r_viol != 0) begin bad++; $display("FAIL %s_handshake got violations=%0d want 0", name, r_viol); end
    endtask

    task automatic test_scan();
        do_reset();
        for (int k = 0; k < N; k++) word[k] = 16'($urandom);
        set_plans(1'b1);
        run_frame(1'b0);
        check_frame("scan");
        total++;
        if (r_busy_cnt != N) begin bad++; $display("FAIL scan_busy got=%0d want=%0d", r_busy_cnt, N); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int k = 0; k < N; k++) word[k] = 16'($urandom);
        set_plans(1'b1);
        rplan[3] = 1'b0; rplan[4] = 1'b0; rplan[5] = 1'b0;
        run_frame(1'b0);
        check_frame("bp");
        total++;
        if (r_hold.size() != 3 || r_hold[0] != 1 || r_hold[1] != 1 || r_hold[2] != 1) begin
            bad++; $display("FAIL bp_hold got n=%0d want 3 cycles held at chan 1", r_hold.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < N; k++) word[k] = 16'($urandom);
        set_plans(1'b1);
        for (int c = 1; c <= 5; c++) vplan[c] = 4'b1011;
        run_frame(1'b0);
        check_frame("stall");
        total++;
        if (r_idle_busy == 0) begin bad++; $display("FAIL stall_gap got empty_cycles=0 want >0"); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            do_reset();
            for (int k = 0; k < N; k++) word[k] = 16'($urandom);
            for (int c = 0; c < 64; c++) begin
                for (int k = 0; k < N; k++) vplan[c][k] = (c >= 40) || ($urandom_range(3, 0) != 0);
                rplan[c] = (c >= 40) || ($urandom_range(3, 0) != 0);
            end
            run_frame(1'b1);
            check_frame("random");
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int k = 0; k < N; k++) word[k] = 16'($urandom);
        bus.in_data = {word[3], word[2], word[1], word[0]};
        @(negedge clk);
        bus.mode = 1'b1; bus.start = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (bus.in_ack !== 4'b0000) begin bad++; $display("FAIL midreset_ack got=%b want=0000", bus.in_ack); end
        @(posedge clk); #1;
        total++;
        if ({bus.out_data, bus.out_chan, bus.out_valid, bus.busy, bus.frame_done} !== 21'd0) begin
            bad++;
            $display("FAIL midreset_outputs got data=%h chan=%0d v=%b busy=%b fd=%b want all 0",
                     bus.out_data, bus.out_chan, bus.out_valid, bus.busy, bus.frame_done);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL midreset_quiet cyc=%0d got fd=%b busy=%b v=%b want 0/0/0",
                                i, bus.frame_done, bus.busy, bus.out_valid);
            end
        end
        set_plans(1'b1);
        run_frame(1'b0);
        check_frame("after_reset");
    endtask

    // Start held high: frames repeat with a period of 1 + N cycles
    task automatic test_back_to_back();
        int pos;
        do_reset();
        for (int k = 0; k < N; k++) word[k] = 16'($urandom);
        bus.in_data = {word[3], word[2], word[1], word[0]};
        @(negedge clk);
        bus.mode = 1'b1; bus.start = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            pos = i % (N + 1);
            total++;
            if (bus.out_valid !== (pos != 0) || bus.busy !== (pos != N) || bus.frame_done !== (pos == N)) begin
                bad++;
                $display("FAIL b2b_status edge=%0d got v=%b busy=%b fd=%b want v=%b busy=%b fd=%b",
                         i, bus.out_valid, bus.busy, bus.frame_done, pos != 0, pos != N, pos == N);
            end
            if (pos != 0) begin
                total++;
                if (int'(bus.out_chan) != pos - 1 || bus.out_data !== word[pos-1]) begin
                    bad++;
                    $display("FAIL b2b_chan edge=%0d got c=%0d d=%h want c=%0d d=%h",
                             i, bus.out_chan, bus.out_data, pos - 1, word[pos-1]);
                end
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.in_data = 64'd0; bus.in_valid = 4'b0000; bus.mode = 1'b0;
        bus.sel = 2'd0; bus.start = 1'b0; bus.out_ready = 1'b1;
        test_reset();
        test_direct();
        test_direct_random();
        test_scan();
        test_back_pressure();
        test_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
